adc128s_model: RTL and testbench

Behavioural model of an 8-channel, 12-bit SPI A2D converter. It serves the load-cell and battery measurements to the Segway controller in system-level simulation. The block is a SPI slave clocked by the system clock: it oversamples the master's SS_n/SCLK/MOSI and answers each 16-bit frame with the conversion result of the channel addressed in the previous complete frame. Three channels return testbench-settable values; all others return zero.

---
 rtl/adc128s_model_if.sv | 14 +
 rtl/adc128s_model.sv | 116 +++++++++++
 tb/tb_adc128s_model.sv | 124 ++++++++++++
 3 files changed

// File: rtl/adc128s_model_if.sv
// SPI bus between a master and the adc128s_model slave.
//   SS_n : active-low slave select (frame boundary), master -> slave
//   SCLK : SPI clock, idles high, master -> slave
//   MOSI : command data, MSB first, master -> slave
//   MISO : reply data, MSB first, slave -> master
interface adc128s_model_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adc128s_model.sv
// Behavioural model of an 8-channel 12-bit SPI A2D converter.
// The SPI pins are oversampled by clk. Each 16-bit frame returns the result
// of the channel addressed by the previous complete frame.
//   clk           : system clock, rising edge
//   rst_n         : synchronous active-low reset
//   spi           : SPI slave port (SS_n, SCLK, MOSI in; MISO out)
//   lft_cell_set  : value returned for channel 0
//   rght_cell_set : value returned for channel 4
//   batt_set      : value returned for channel 5
module adc128s_model (
  input  logic            clk,
  input  logic            rst_n,
  adc128s_model_if.slave  spi,
  input  logic [11:0]     lft_cell_set,
  input  logic [11:0]     rght_cell_set,
  input  logic [11:0]     batt_set
);

  // Synchronisers: ff1/ff2 resolve metastability; ff3 is the previous
  // synced value for edge detect. Reset to the bus idle state.
  logic r_ss_ff1, r_ss_ff2, r_ss_ff3;
  logic r_sclk_ff1, r_sclk_ff2, r_sclk_ff3;
  logic r_mosi_ff1, r_mosi_ff2;

  logic [15:0] r_tx;
  logic [15:0] r_rx;
  logic [4:0]  r_bit_cnt;
  logic [2:0]  r_chnl;
  logic        r_miso;

  logic        w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall, w_in_frame;
  logic [11:0] w_chnl_val;
  logic [15:0] w_tx_nxt, w_rx_nxt;
  logic [4:0]  w_cnt_nxt;
  logic [2:0]  w_chnl_nxt;

  assign w_ss_fall   = ~r_ss_ff2 &  r_ss_ff3;
  assign w_ss_rise   =  r_ss_ff2 & ~r_ss_ff3;
  assign w_sclk_rise =  r_sclk_ff2 & ~r_sclk_ff3;
  assign w_sclk_fall = ~r_sclk_ff2 &  r_sclk_ff3;
  assign w_in_frame  = ~r_ss_ff2;

  always_comb begin
    w_chnl_val = 12'h000;
    case (r_chnl)
      3'd0:    w_chnl_val = lft_cell_set;
      3'd4:    w_chnl_val = rght_cell_set;
      3'd5:    w_chnl_val = batt_set;
      default: w_chnl_val = 12'h000;
    endcase
  end

  always_comb begin
    w_tx_nxt   = r_tx;
    w_rx_nxt   = r_rx;
    w_cnt_nxt  = r_bit_cnt;
    w_chnl_nxt = r_chnl;
    if (w_ss_fall) begin
      // Frame start has priority over any coincident SCLK edge; the reply
      // value is captured here so later *_set changes miss this frame.
      w_tx_nxt  = {4'h0, w_chnl_val};
      w_rx_nxt  = 16'h0000;
      w_cnt_nxt = 5'd0;
    end else if (w_ss_rise) begin
      // Only a full 16-bit frame may retarget the channel.
      if (r_bit_cnt == 5'd16)
        w_chnl_nxt = r_rx[13:11];
    end else if (w_in_frame) begin
      if (w_sclk_rise) begin
        w_rx_nxt = {r_rx[14:0], r_mosi_ff2};
        if (r_bit_cnt != 5'd16)
          w_cnt_nxt = r_bit_cnt + 5'd1;
      end else if (w_sclk_fall && (r_bit_cnt != 5'd0)) begin
        // A fall before the first rise (SCLK leaving idle) must not shift,
        // otherwise bit 15 would be lost before the master samples it.
        w_tx_nxt = {r_tx[14:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ss_ff1   <= 1'b1;
      r_ss_ff2   <= 1'b1;
      r_ss_ff3   <= 1'b1;
      r_sclk_ff1 <= 1'b1;
      r_sclk_ff2 <= 1'b1;
      r_sclk_ff3 <= 1'b1;
      r_mosi_ff1 <= 1'b0;
      r_mosi_ff2 <= 1'b0;
      r_tx       <= 16'h0000;
      r_rx       <= 16'h0000;
      r_bit_cnt  <= 5'd0;
      r_chnl     <= 3'd0;
      r_miso     <= 1'b0;
    end else begin
      r_ss_ff1   <= spi.SS_n;
      r_ss_ff2   <= r_ss_ff1;
      r_ss_ff3   <= r_ss_ff2;
      r_sclk_ff1 <= spi.SCLK;
      r_sclk_ff2 <= r_sclk_ff1;
      r_sclk_ff3 <= r_sclk_ff2;
      r_mosi_ff1 <= spi.MOSI;
      r_mosi_ff2 <= r_mosi_ff1;
      r_tx       <= w_tx_nxt;
      r_rx       <= w_rx_nxt;
      r_bit_cnt  <= w_cnt_nxt;
      r_chnl     <= w_chnl_nxt;
      // Registered MISO follows the next tx MSB, forced low outside a frame.
      r_miso     <= w_in_frame & w_tx_nxt[15];
    end
  end

  assign spi.MISO = r_miso;

endmodule

// File: tb/tb_adc128s_model.sv
module tb_adc128s_model;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] lft_cell_set, rght_cell_set, batt_set;
  int          checks = 0;
  int          errors = 0;
  logic [2:0]  m_chnl;     // model: channel addressed by last full frame
  logic [15:0] rep;

  adc128s_model_if spi ();

  adc128s_model dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spi           (spi.slave),
    .lft_cell_set  (lft_cell_set),
    .rght_cell_set (rght_cell_set),
    .batt_set      (batt_set)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] chval(input logic [2:0] ch);
    case (ch)
      3'd0:    return lft_cell_set;
      3'd4:    return rght_cell_set;
      3'd5:    return batt_set;
      default: return 12'h000;
    endcase
  endfunction

  // Idle SS_n high: after the sync latency MISO must read 0 every cycle.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k >= 4) chk("miso_idle", {15'd0, spi.MISO}, 16'h0000);
    end
  endtask

  // One SPI frame, 16 clk per SCLK period. Each MISO bit is checked
  // against the model's expected reply at the master's sample point.
  task automatic frame(input logic [2:0] ch, input int nbits, input bit midchg,
                       input bit do_rst, output logic [15:0] r);
    logic [15:0] cmd, exp;
    cmd = {2'b00, ch, 11'h000};
    exp = {4'h0, chval(m_chnl)};
    r   = 16'h0000;
    @(posedge clk);
    spi.SS_n = 1'b0;
    spi.MOSI = 1'b0;
    repeat (8) @(posedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi.SCLK = 1'b0;
      spi.MOSI = cmd[15-i];
      repeat (8) @(posedge clk);
      if (midchg && i == 4) rght_cell_set = 12'h7FF;
      spi.SCLK = 1'b1;
      @(negedge clk);
      r[15-i] = spi.MISO;
      chk($sformatf("miso_bit%0d", 15-i), {15'd0, spi.MISO}, {15'd0, exp[15-i]});
      repeat (7) @(posedge clk);
    end
    if (do_rst) begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      m_chnl = 3'd0;
    end
    spi.SS_n = 1'b1;
    if (nbits == 16 && !do_rst) m_chnl = ch;
    idle(12);
  endtask

  initial begin
    rst_n    = 1'b0;
    spi.SS_n = 1'b1;
    spi.SCLK = 1'b1;
    spi.MOSI = 1'b0;
    lft_cell_set  = 12'h110;
    rght_cell_set = 12'h100;
    batt_set      = 12'hABC;
    m_chnl = 3'd0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_miso", {15'd0, spi.MISO}, 16'h0000);
    @(posedge clk);
    rst_n = 1'b1;
    idle(8);

    frame(3'd5, 16, 1'b0, 1'b0, rep); chk("f1_reset_ch0", rep, 16'h0110);
    frame(3'd0, 16, 1'b0, 1'b0, rep); chk("f2_batt",      rep, 16'h0ABC);
    frame(3'd4, 16, 1'b0, 1'b0, rep); chk("f3_lft",       rep, 16'h0110);
    frame(3'd4, 16, 1'b1, 1'b0, rep); chk("f4_rght_hold", rep, 16'h0100);
    frame(3'd3, 16, 1'b0, 1'b0, rep); chk("f5_rght_new",  rep, 16'h07FF);
    frame(3'd5, 16, 1'b0, 1'b0, rep); chk("f6_ch3_zero",  rep, 16'h0000);
    frame(3'd4,  8, 1'b0, 1'b0, rep); chk("f7_abort_hi",  rep, 16'h0A00);
    frame(3'd0, 16, 1'b0, 1'b0, rep); chk("f8_after_abort", rep, 16'h0ABC);
    frame(3'd5, 16, 1'b0, 1'b0, rep); chk("f9_lft",       rep, 16'h0110);
    frame(3'd1,  5, 1'b0, 1'b1, rep);
    frame(3'd2, 16, 1'b0, 1'b0, rep); chk("f11_post_rst", rep, 16'h0110);
    frame(3'd6, 16, 1'b0, 1'b0, rep); chk("f12_ch2_zero", rep, 16'h0000);
    batt_set = 12'h123;
    frame(3'd5, 16, 1'b0, 1'b0, rep); chk("f13_ch6_zero", rep, 16'h0000);
    frame(3'd0, 16, 1'b0, 1'b0, rep); chk("f14_batt2",    rep, 16'h0123);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
